dmem_access_unit: RTL
=====================

// Module: dmem_access_unit
// PURPOSE
//  Data-memory access stage between EX (ALU address, rs2 store data) and the load extractor.
//  Checks alignment, builds the word-aligned address, byte write mask and shifted store data.
//  Runs the valid/ready request handshake with a variable-latency data memory.
//  Returns the raw read word and byte offset, which the load extractor sign/zero-extends.
//  Drives stall to the pipeline while an access is outstanding.
// PARAMETERS
//  TIMEOUT  255  max cycles in WAIT_R without mem_rvalid before an error response; 0 disables
// PORTS
//  clk          in   1   core clock; all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   EX stage presents an access
//  req_ready    out  1   unit can accept; high only in IDLE
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word; 11 is treated as word
//  req_addr     in   32  byte address (ALU output)
//  req_wdata    in   32  store data, value in the low bits
//  mem_valid    out  1   request to memory
//  mem_ready    in   1   memory accepts request
//  mem_we       out  1   write enable
//  mem_addr     out  32  {req_addr[31:2],2'b00}
//  mem_wmask    out  4   byte enables; 0000 on reads
//  mem_wdata    out  32  req_wdata << (8*req_addr[1:0])
//  mem_rvalid   in   1   read data valid
//  mem_rdata    in   32  read word
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  raw word, captured from mem_rdata on read; 0 for stores and errors
//  rsp_offset   out  2   latched req_addr[1:0], passed to the load extractor
//  rsp_err      out  1   misaligned access or read timeout
//  stall        out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE; all outputs 0 except req_ready=1; timeout counter=0.
//  States: IDLE, REQ, WAIT_R, RESP
//   - IDLE: accept when req_valid&&req_ready; latch we/size/addr/wdata.
//     - Misaligned -> RESP with err=1; no memory request is issued.
//     - Otherwise -> REQ.
//   - REQ: mem_valid=1; mem_* held stable until mem_ready.
//     - Handshake on a store -> RESP (posted write).
//     - Handshake on a load -> WAIT_R; counter cleared.
//   - WAIT_R: mem_rvalid=1 -> capture mem_rdata into rsp_rdata, -> RESP.
//     - Otherwise counter++; counter==TIMEOUT (TIMEOUT!=0) -> RESP with err=1, rdata=0.
//   - RESP: rsp_valid=1 for exactly one cycle; no backpressure; -> IDLE.
//     - rsp_rdata, rsp_offset and rsp_err hold their values until the next RESP.
//  Misaligned rules
//   - word with addr[1:0]!=0 is misaligned.
//   - half with addr[1:0]==3 is misaligned; half at offset 1 is legal, as the extractor supports it.
//  Write mask
//   - byte: 0001<<off; half: 0011<<off; word: 1111.
//  mem_rvalid is sampled only in WAIT_R; rvalid in any other state is ignored.
//   - A read response in the handshake cycle itself is therefore not seen; memory must return data at least 1 cycle later.
//  Reset mid-access -> IDLE immediately; a late mem_rvalid after reset is ignored.
//  Latency, with acceptance at cycle N (req_valid&&req_ready sampled in IDLE at N)
//   - mem_valid is asserted at N+1.
//   - Store with mem_ready=1 at N+1: rsp_valid at N+2.
//   - Load with mem_ready=1 at N+1 and mem_rvalid=1 at N+2: rsp_valid at N+3.
//   - Misaligned access: rsp_valid at N+1.
//  TIMEOUT width: counter is $clog2(TIMEOUT+1) bits; saturates and does not wrap.
// STRUCTURE
//  - Shared header dmem_defs.vh: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and state encodings.
//  - One combinational sub-module, dmem_store_align:
//    - inputs: size, offset, wdata;
//    - outputs: wmask, shifted wdata, misaligned flag.
//  - FSM, latches and timeout counter stay in this module.
// TESTING
//  1. sw: addr=0x100, data=0xDEADBEEF, mem_ready at once.
//     -> mem_addr=0x100, wmask=1111, wdata=0xDEADBEEF; rsp_valid at N+2, err=0.
//  2. sb: addr=0x203, data=0x000000AB.
//     -> mem_addr=0x200, wmask=1000, wdata=0xAB000000.
//  3. lh: addr=0x301; mem_ready delayed 3 cycles, rdata=0x12345678.
//     -> mem_valid held 3 cycles with stable fields; rsp_rdata=0x12345678, offset=1.
//  4. lw at 0x402 and lh at 0x403.
//     -> mem_valid never asserted; rsp_valid at N+1 with err=1 and rdata=0.
//  5. TIMEOUT=4, load with mem_rvalid never asserted.
//     -> rsp_valid with err=1 after 4 WAIT_R cycles; stall high throughout.
//  6. Assert rst_n=0 in WAIT_R, then drive mem_rvalid after release.
//     -> outputs return to reset values; no rsp_valid is produced.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: access sizes and FSM states.
package dmem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT_R = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

endpackage

// File: rtl/dmem_store_align.sv
// Combinational store alignment: byte enables, lane-shifted store data and misalignment flag.
module dmem_store_align
    import dmem_access_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    always_comb begin
        wmask_o      = 4'b1111;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: wmask_o = 4'b0001 << offset_i;
            SZ_HALF: begin
                // Offset 1 stays legal: the load extractor handles the straddling half.
                wmask_o      = 4'b0011 << offset_i;
                misaligned_o = (offset_i == 2'd3);
            end
            SZ_WORD: misaligned_o = (offset_i != 2'd0);
            default: misaligned_o = (offset_i != 2'd0);
        endcase
    end

    assign wdata_o = wdata_i << {offset_i, 3'b000};

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: alignment check, valid/ready memory request, read-response
// capture with timeout, and pipeline stall while an access is outstanding.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_offset_o,
    output logic        rsp_err_o,
    output logic        stall_o
);

    // state   | meaning
    // IDLE    | ready for a new access
    // REQ     | mem_valid up, waiting for mem_ready
    // WAIT_R  | load accepted, waiting for mem_rvalid or timeout
    // RESP    | one-cycle completion pulse

    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_offset_q, rsp_offset_d;
    logic        rsp_err_q, rsp_err_d;

    logic [3:0]  al_wmask;
    logic [31:0] al_wdata;
    logic        al_misaligned;

    dmem_store_align u_align (
        .size_i       (req_size_i),
        .offset_i     (req_addr_i[1:0]),
        .wdata_i      (req_wdata_i),
        .wmask_o      (al_wmask),
        .wdata_o      (al_wdata),
        .misaligned_o (al_misaligned)
    );

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_offset_d = rsp_offset_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wmask_d = req_we_i ? al_wmask : 4'b0000;
                    wdata_d = al_wdata;
                    if (al_misaligned) begin
                        state_d      = ST_RESP;
                        rsp_err_d    = 1'b1;
                        rsp_rdata_d  = 32'h0;
                        rsp_offset_d = req_addr_i[1:0];
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    if (we_q) begin
                        state_d      = ST_RESP;
                        rsp_err_d    = 1'b0;
                        rsp_rdata_d  = 32'h0;
                        rsp_offset_d = addr_q[1:0];
                    end else begin
                        state_d = ST_WAIT_R;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid_i) begin
                    state_d      = ST_RESP;
                    rsp_err_d    = 1'b0;
                    rsp_rdata_d  = mem_rdata_i;
                    rsp_offset_d = addr_q[1:0];
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_inc;
                    if (TIMEOUT != 0 && cnt_inc == TO_VAL) begin
                        state_d      = ST_RESP;
                        rsp_err_d    = 1'b1;
                        rsp_rdata_d  = 32'h0;
                        rsp_offset_d = addr_q[1:0];
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wmask_q      <= 4'b0000;
            wdata_q      <= 32'h0;
            cnt_q        <= '0;
            rsp_rdata_q  <= 32'h0;
            rsp_offset_q <= 2'b00;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_offset_q <= rsp_offset_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign stall_o      = (state_q != ST_IDLE);
    assign mem_valid_o  = (state_q == ST_REQ);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = {addr_q[31:2], 2'b00};
    assign mem_wmask_o  = wmask_q;
    assign mem_wdata_o  = wdata_q;
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_offset_o = rsp_offset_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
